// File: rtl/mem_access_unit.sv
// Memory-access stage: turns load/store requests into single-word bus transfers,
// extracts and extends load data, and raises misalign and bus-timeout faults.
module mem_access_unit #(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic [31:0] ALUResult_i,
    input  logic [31:0] RDData_i,
    input  logic [4:0]  rd_i,
    input  logic        RegWrite_i,
    input  logic        MemRead_i,
    input  logic        MemWrite_i,
    input  logic        LoadMux_i,
    input  logic [2:0]  LoadstoreSigodecoder_i,
    output logic        dmem_req_o,
    output logic        dmem_we_o,
    output logic [31:0] dmem_addr_o,
    output logic [3:0]  dmem_be_o,
    output logic [31:0] dmem_wdata_o,
    input  logic        dmem_ack_i,
    input  logic [31:0] dmem_rdata_i,
    output logic        stall_o,
    output logic [31:0] wbData_o,
    output logic [4:0]  rd_o,
    output logic        RegWrite_o,
    output logic        valid_o,
    output logic        misalign_o,
    output logic        buserr_o
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [0:0] {IDLE = 1'b0, WAIT = 1'b1} state_t;

    function automatic logic [3:0] lane_be(input logic [2:0] f3, input logic [1:0] a);
        case (f3[1:0])
            2'b00:   lane_be = 4'b0001 << a;
            2'b01:   lane_be = a[1] ? 4'b1100 : 4'b0011;
            default: lane_be = 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] lane_wdata(input logic [2:0] f3, input logic [31:0] d);
        case (f3[1:0])
            2'b00:   lane_wdata = {4{d[7:0]}};
            2'b01:   lane_wdata = {2{d[15:0]}};
            default: lane_wdata = d;
        endcase
    endfunction

    function automatic logic [31:0] load_extract(input logic [2:0] f3, input logic [1:0] a,
                                                 input logic [31:0] w);
        logic [7:0]  b;
        logic [15:0] h;
        case (a)
            2'b00:   b = w[7:0];
            2'b01:   b = w[15:8];
            2'b10:   b = w[23:16];
            default: b = w[31:24];
        endcase
        h = a[1] ? w[31:16] : w[15:0];
        case (f3)
            3'b000:  load_extract = {{24{b[7]}}, b};
            3'b001:  load_extract = {{16{h[15]}}, h};
            3'b100:  load_extract = {24'h000000, b};
            3'b101:  load_extract = {16'h0000, h};
            default: load_extract = w;
        endcase
    endfunction

    function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] a);
        case (f3[1:0])
            2'b00:   is_misaligned = 1'b0;
            2'b01:   is_misaligned = a[0];
            default: is_misaligned = (a != 2'b00);
        endcase
    endfunction

    state_t           state_r, state_nx_s;
    logic [CNT_W-1:0] cnt_r;
    logic [31:0]      addr_r, wdata_r;
    logic [2:0]       f3_r;
    logic [3:0]       be_r;
    logic [4:0]       rd_r;
    logic             regwrite_r, loadmux_r, we_r;
    logic [31:0]      wb_r;
    logic [4:0]       rd_out_r;
    logic             rw_out_r, valid_r, misalign_r, buserr_r;
    logic             mem_op_s, misaligned_s;
    logic             stall_s, req_s, accept_s, mis_fault_s, pass_s, done_s, timeout_s;

    assign mem_op_s     = MemRead_i | MemWrite_i;
    assign misaligned_s = is_misaligned(LoadstoreSigodecoder_i, ALUResult_i[1:0]);

    // State register.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // Next state and per-cycle control; an abandoned or faulting access never stalls its successor.
    always_comb begin
        state_nx_s  = state_r;
        stall_s     = 1'b0;
        req_s       = 1'b0;
        accept_s    = 1'b0;
        mis_fault_s = 1'b0;
        pass_s      = 1'b0;
        done_s      = 1'b0;
        timeout_s   = 1'b0;
        if (reset_i) begin
            state_nx_s = IDLE;
        end else begin
            case (state_r)
                IDLE: begin
                    if (!mem_op_s) begin
                        pass_s = 1'b1;
                    end else if (misaligned_s) begin
                        mis_fault_s = 1'b1;
                    end else begin
                        accept_s   = 1'b1;
                        stall_s    = 1'b1;
                        state_nx_s = WAIT;
                    end
                end
                WAIT: begin
                    req_s = 1'b1;
                    if (dmem_ack_i) begin
                        done_s     = 1'b1;
                        state_nx_s = IDLE;
                    end else if (cnt_r == CNT_LAST) begin
                        timeout_s  = 1'b1;
                        state_nx_s = IDLE;
                    end else begin
                        stall_s = 1'b1;
                    end
                end
                default: state_nx_s = IDLE;
            endcase
        end
    end

    // Access latch, wait counter and registered write-back/fault outputs.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            cnt_r      <= '0;
            addr_r     <= 32'h0;
            wdata_r    <= 32'h0;
            f3_r       <= 3'b000;
            be_r       <= 4'b0000;
            rd_r       <= 5'd0;
            regwrite_r <= 1'b0;
            loadmux_r  <= 1'b0;
            we_r       <= 1'b0;
            wb_r       <= 32'h0;
            rd_out_r   <= 5'd0;
            rw_out_r   <= 1'b0;
            valid_r    <= 1'b0;
            misalign_r <= 1'b0;
            buserr_r   <= 1'b0;
        end else begin
            valid_r    <= pass_s | mis_fault_s | done_s | timeout_s;
            misalign_r <= mis_fault_s;
            buserr_r   <= timeout_s;
            if (pass_s) begin
                wb_r     <= ALUResult_i;
                rd_out_r <= rd_i;
                rw_out_r <= RegWrite_i;
            end else if (mis_fault_s) begin
                wb_r     <= ALUResult_i;
                rd_out_r <= rd_i;
                rw_out_r <= 1'b0;
            end else if (done_s) begin
                wb_r     <= loadmux_r ? load_extract(f3_r, addr_r[1:0], dmem_rdata_i) : addr_r;
                rd_out_r <= rd_r;
                rw_out_r <= regwrite_r;
            end else if (timeout_s) begin
                wb_r     <= addr_r;
                rd_out_r <= rd_r;
                rw_out_r <= 1'b0;
            end else begin
                rw_out_r <= 1'b0;
            end
            if (accept_s) begin
                cnt_r      <= '0;
                addr_r     <= ALUResult_i;
                f3_r       <= LoadstoreSigodecoder_i;
                be_r       <= lane_be(LoadstoreSigodecoder_i, ALUResult_i[1:0]);
                wdata_r    <= lane_wdata(LoadstoreSigodecoder_i, RDData_i);
                rd_r       <= rd_i;
                regwrite_r <= RegWrite_i;
                loadmux_r  <= LoadMux_i;
                we_r       <= MemWrite_i;
            end else if (state_r == WAIT) begin
                cnt_r <= cnt_r + CNT_W'(1);
            end else begin
                cnt_r <= cnt_r;
            end
        end
    end

    assign dmem_req_o   = req_s;
    assign dmem_we_o    = req_s & we_r;
    assign dmem_be_o    = req_s ? be_r : 4'b0000;
    assign dmem_addr_o  = {addr_r[31:2], 2'b00};
    assign dmem_wdata_o = wdata_r;
    assign stall_o      = stall_s;
    assign wbData_o     = wb_r;
    assign rd_o         = rd_out_r;
    assign RegWrite_o   = rw_out_r;
    assign valid_o      = valid_r;
    assign misalign_o   = misalign_r;
    assign buserr_o     = buserr_r;

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit: expected write-backs are queued when an
// operation is driven and popped when valid_o reports the result.
module tb_mem_access_unit;

    logic        clk;
    logic        reset_i;
    logic [31:0] ALUResult_i, RDData_i, dmem_rdata_i;
    logic [4:0]  rd_i;
    logic        RegWrite_i, MemRead_i, MemWrite_i, LoadMux_i, dmem_ack_i;
    logic [2:0]  LoadstoreSigodecoder_i;
    logic        dmem_req_o, dmem_we_o, stall_o, RegWrite_o, valid_o, misalign_o, buserr_o;
    logic [31:0] dmem_addr_o, dmem_wdata_o, wbData_o;
    logic [3:0]  dmem_be_o;
    logic [4:0]  rd_o;

    typedef struct {
        logic [31:0] wb;
        logic [4:0]  rd;
        logic        rw;
        logic        mis;
        logic        berr;
    } exp_t;

    typedef struct {
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] rdata;
        int          delay;
        logic [31:0] wb;
        logic [3:0]  be;
    } ld_t;

    typedef struct {
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] data;
        logic        mr;
        logic [3:0]  be;
        logic [31:0] wdata;
    } st_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    mem_access_unit #(.TIMEOUT_CYCLES(16)) dut (
        .clk_i(clk), .reset_i(reset_i),
        .ALUResult_i(ALUResult_i), .RDData_i(RDData_i), .rd_i(rd_i), .RegWrite_i(RegWrite_i),
        .MemRead_i(MemRead_i), .MemWrite_i(MemWrite_i), .LoadMux_i(LoadMux_i),
        .LoadstoreSigodecoder_i(LoadstoreSigodecoder_i),
        .dmem_req_o(dmem_req_o), .dmem_we_o(dmem_we_o), .dmem_addr_o(dmem_addr_o),
        .dmem_be_o(dmem_be_o), .dmem_wdata_o(dmem_wdata_o),
        .dmem_ack_i(dmem_ack_i), .dmem_rdata_i(dmem_rdata_i),
        .stall_o(stall_o), .wbData_o(wbData_o), .rd_o(rd_o), .RegWrite_o(RegWrite_o),
        .valid_o(valid_o), .misalign_o(misalign_o), .buserr_o(buserr_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic drive_idle();
        MemRead_i = 1'b0; MemWrite_i = 1'b0; LoadMux_i = 1'b0; RegWrite_i = 1'b0;
        ALUResult_i = 32'h0; RDData_i = 32'h0; rd_i = 5'd0; LoadstoreSigodecoder_i = 3'b000;
        dmem_ack_i = 1'b0; dmem_rdata_i = 32'h0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input logic [2:0] f3, input logic [31:0] addr, input logic mr,
                          input logic mw, input logic lm, input logic [4:0] rd,
                          input logic rw, input logic [31:0] data);
        LoadstoreSigodecoder_i = f3; ALUResult_i = addr; MemRead_i = mr; MemWrite_i = mw;
        LoadMux_i = lm; rd_i = rd; RegWrite_i = rw; RDData_i = data;
    endtask

    task automatic test_reset();
        reset_i = 1'b1;
        set_op(3'b010, 32'h1000, 1'b1, 1'b0, 1'b1, 5'd1, 1'b1, 32'h0);
        dmem_ack_i = 1'b1;
        next_cycle();
        next_cycle();
        @(negedge clk);
        n_cmp++;
        if ({wbData_o, rd_o, RegWrite_o, valid_o, misalign_o, buserr_o} !== 41'h0) begin
            n_bad++;
            $display("FAIL reset_regs: got wb=%h rd=%0d rw=%b v=%b mis=%b berr=%b, want all 0",
                     wbData_o, rd_o, RegWrite_o, valid_o, misalign_o, buserr_o);
        end
        n_cmp++;
        if ({dmem_req_o, dmem_we_o, dmem_be_o, stall_o} !== 7'b0) begin
            n_bad++;
            $display("FAIL reset_bus: got req=%b we=%b be=%b stall=%b, want 0",
                     dmem_req_o, dmem_we_o, dmem_be_o, stall_o);
        end
        next_cycle();
        reset_i = 1'b0;
        drive_idle();
        @(negedge clk);
    endtask

    task automatic test_passthrough();
        logic [31:0] vals [3] = '{32'h0000_0055, 32'hFFFF_0000, 32'h1234_5678};
        logic [4:0]  rds  [3] = '{5'd5, 5'd31, 5'd1};
        logic        rws  [3] = '{1'b1, 1'b0, 1'b1};
        exp_t e;
        for (int i = 0; i < 3; i++) begin
            next_cycle();
            set_op(3'b000, vals[i], 1'b0, 1'b0, 1'b0, rds[i], rws[i], 32'h0);
            exp_q.push_back('{vals[i], rds[i], rws[i], 1'b0, 1'b0});
            @(negedge clk);
            n_cmp++;
            if ({stall_o, dmem_req_o, dmem_be_o} !== 6'b0) begin
                n_bad++;
                $display("FAIL alu_bus[%0d]: got stall=%b req=%b be=%b, want 0", i, stall_o, dmem_req_o, dmem_be_o);
            end
            next_cycle();
            drive_idle();
            @(negedge clk);
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_bad++;
                $display("FAIL alu_wb[%0d]: scoreboard empty", i);
            end else begin
                e = exp_q.pop_front();
                if ({valid_o, wbData_o, rd_o, RegWrite_o, misalign_o, buserr_o} !== {1'b1, e.wb, e.rd, e.rw, e.mis, e.berr}) begin
                    n_bad++;
                    $display("FAIL alu_wb[%0d]: got v=%b wb=%h rd=%0d rw=%b, want v=1 wb=%h rd=%0d rw=%b",
                             i, valid_o, wbData_o, rd_o, RegWrite_o, e.wb, e.rd, e.rw);
                end
            end
        end
    endtask

    task automatic test_loads();
        ld_t lt [6];
        exp_t e;
        int stall_cnt;
        lt[0] = '{3'b000, 32'h0000_1003, 32'h80FF_1234, 3, 32'hFFFF_FF80, 4'b1000};
        lt[1] = '{3'b001, 32'h0000_0002, 32'h8001_7FFF, 1, 32'hFFFF_8001, 4'b1100};
        lt[2] = '{3'b101, 32'h0000_0000, 32'h1234_F00D, 1, 32'h0000_F00D, 4'b0011};
        lt[3] = '{3'b100, 32'h0000_0001, 32'h0000_9A00, 2, 32'h0000_009A, 4'b0010};
        lt[4] = '{3'b010, 32'h0000_0008, 32'hCAFE_BABE, 1, 32'hCAFE_BABE, 4'b1111};
        lt[5] = '{3'b000, 32'h0000_0002, 32'h007F_0000, 1, 32'h0000_007F, 4'b0100};
        for (int i = 0; i < 6; i++) begin
            next_cycle();
            set_op(lt[i].f3, lt[i].addr, 1'b1, 1'b0, 1'b1, 5'(i + 1), 1'b1, 32'h0);
            exp_q.push_back('{lt[i].wb, 5'(i + 1), 1'b1, 1'b0, 1'b0});
            @(negedge clk);
            stall_cnt = int'(stall_o);
            for (int w = 1; w <= lt[i].delay; w++) begin
                next_cycle();
                if (w == lt[i].delay) begin
                    dmem_ack_i = 1'b1;
                    dmem_rdata_i = lt[i].rdata;
                end
                @(negedge clk);
                stall_cnt += int'(stall_o);
                n_cmp++;
                if ({dmem_req_o, dmem_we_o, dmem_be_o, dmem_addr_o, valid_o} !==
                    {1'b1, 1'b0, lt[i].be, lt[i].addr & 32'hFFFF_FFFC, 1'b0}) begin
                    n_bad++;
                    $display("FAIL ld_bus[%0d.%0d]: got req=%b we=%b be=%b addr=%h v=%b, want req=1 we=0 be=%b addr=%h v=0",
                             i, w, dmem_req_o, dmem_we_o, dmem_be_o, dmem_addr_o, valid_o,
                             lt[i].be, lt[i].addr & 32'hFFFF_FFFC);
                end
            end
            next_cycle();
            drive_idle();
            @(negedge clk);
            n_cmp++;
            if (stall_cnt != lt[i].delay) begin
                n_bad++;
                $display("FAIL ld_stall[%0d]: got %0d stall cycles, want %0d", i, stall_cnt, lt[i].delay);
            end
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_bad++;
                $display("FAIL ld_wb[%0d]: scoreboard empty", i);
            end else begin
                e = exp_q.pop_front();
                if ({valid_o, wbData_o, rd_o, RegWrite_o, misalign_o, buserr_o} !== {1'b1, e.wb, e.rd, e.rw, e.mis, e.berr}) begin
                    n_bad++;
                    $display("FAIL ld_wb[%0d]: got v=%b wb=%h rd=%0d rw=%b, want v=1 wb=%h rd=%0d rw=%b",
                             i, valid_o, wbData_o, rd_o, RegWrite_o, e.wb, e.rd, e.rw);
                end
            end
        end
    endtask

    task automatic test_stores();
        st_t st [4];
        exp_t e;
        st[0] = '{3'b001, 32'h0000_2002, 32'hDEAD_BEEF, 1'b0, 4'b1100, 32'hBEEF_BEEF};
        st[1] = '{3'b000, 32'h0000_2001, 32'h0000_00A5, 1'b1, 4'b0010, 32'hA5A5_A5A5};
        st[2] = '{3'b011, 32'h0000_2004, 32'h1234_5678, 1'b0, 4'b1111, 32'h1234_5678};
        st[3] = '{3'b110, 32'h0000_2008, 32'hA1B2_C3D4, 1'b1, 4'b1111, 32'hA1B2_C3D4};
        for (int i = 0; i < 4; i++) begin
            next_cycle();
            set_op(st[i].f3, st[i].addr, st[i].mr, 1'b1, 1'b0, 5'(10 + i), 1'b0, st[i].data);
            exp_q.push_back('{st[i].addr, 5'(10 + i), 1'b0, 1'b0, 1'b0});
            @(negedge clk);
            n_cmp++;
            if ({stall_o, dmem_req_o} !== 2'b10) begin
                n_bad++;
                $display("FAIL st_accept[%0d]: got stall=%b req=%b, want stall=1 req=0", i, stall_o, dmem_req_o);
            end
            next_cycle();
            dmem_ack_i = 1'b1;
            @(negedge clk);
            n_cmp++;
            if ({dmem_req_o, dmem_we_o, dmem_be_o, dmem_addr_o, dmem_wdata_o, stall_o} !==
                {1'b1, 1'b1, st[i].be, st[i].addr & 32'hFFFF_FFFC, st[i].wdata, 1'b0}) begin
                n_bad++;
                $display("FAIL st_bus[%0d]: got req=%b we=%b be=%b addr=%h wdata=%h stall=%b, want 1 1 %b %h %h 0",
                         i, dmem_req_o, dmem_we_o, dmem_be_o, dmem_addr_o, dmem_wdata_o, stall_o,
                         st[i].be, st[i].addr & 32'hFFFF_FFFC, st[i].wdata);
            end
            next_cycle();
            drive_idle();
            @(negedge clk);
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_bad++;
                $display("FAIL st_wb[%0d]: scoreboard empty", i);
            end else begin
                e = exp_q.pop_front();
                if ({valid_o, wbData_o, rd_o, RegWrite_o, misalign_o, buserr_o} !== {1'b1, e.wb, e.rd, e.rw, e.mis, e.berr}) begin
                    n_bad++;
                    $display("FAIL st_wb[%0d]: got v=%b wb=%h rd=%0d rw=%b, want v=1 wb=%h rd=%0d rw=%b",
                             i, valid_o, wbData_o, rd_o, RegWrite_o, e.wb, e.rd, e.rw);
                end
            end
        end
    endtask

    task automatic test_misalign();
        logic [2:0]  f3s   [4] = '{3'b010, 3'b001, 3'b101, 3'b010};
        logic [31:0] addrs [4] = '{32'h3001, 32'h3003, 32'h3005, 32'h3002};
        logic        mws   [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
        exp_t e;
        for (int i = 0; i < 4; i++) begin
            next_cycle();
            set_op(f3s[i], addrs[i], ~mws[i], mws[i], 1'b1, 5'(20 + i), 1'b1, 32'hFFFF_FFFF);
            exp_q.push_back('{32'h0, 5'(20 + i), 1'b0, 1'b1, 1'b0});
            @(negedge clk);
            n_cmp++;
            if ({dmem_req_o, stall_o, dmem_be_o} !== 6'b0) begin
                n_bad++;
                $display("FAIL mis_bus[%0d]: got req=%b stall=%b be=%b, want 0", i, dmem_req_o, stall_o, dmem_be_o);
            end
            next_cycle();
            drive_idle();
            @(negedge clk);
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_bad++;
                $display("FAIL mis_wb[%0d]: scoreboard empty", i);
            end else begin
                e = exp_q.pop_front();
                if ({valid_o, rd_o, RegWrite_o, misalign_o, buserr_o} !== {1'b1, e.rd, e.rw, e.mis, e.berr}) begin
                    n_bad++;
                    $display("FAIL mis_wb[%0d]: got v=%b rd=%0d rw=%b mis=%b berr=%b, want v=1 rd=%0d rw=0 mis=1 berr=0",
                             i, valid_o, rd_o, RegWrite_o, misalign_o, buserr_o, e.rd);
                end
            end
            next_cycle();
            @(negedge clk);
            n_cmp++;
            if (misalign_o !== 1'b0) begin
                n_bad++;
                $display("FAIL mis_pulse[%0d]: got misalign=%b one cycle later, want 0", i, misalign_o);
            end
        end
    endtask

    task automatic test_timeout();
        exp_t e;
        int   n_req;
        logic prev_stall;
        logic done;
        next_cycle();
        set_op(3'b101, 32'h0000_4002, 1'b1, 1'b0, 1'b1, 5'd3, 1'b1, 32'h0);
        exp_q.push_back('{32'h0, 5'd3, 1'b0, 1'b0, 1'b1});
        @(negedge clk);
        n_req = 0;
        prev_stall = stall_o;
        done = 1'b0;
        for (int i = 0; i < 40 && !done; i++) begin
            next_cycle();
            if (!prev_stall) drive_idle();
            @(negedge clk);
            if (dmem_req_o) begin
                n_req++;
                prev_stall = stall_o;
            end else begin
                done = 1'b1;
            end
        end
        n_cmp++;
        if (n_req != 16) begin
            n_bad++;
            $display("FAIL to_cycles: got %0d WAIT cycles with req, want 16", n_req);
        end
        n_cmp++;
        if (exp_q.size() == 0) begin
            n_bad++;
            $display("FAIL to_wb: scoreboard empty");
        end else begin
            e = exp_q.pop_front();
            if ({valid_o, rd_o, RegWrite_o, misalign_o, buserr_o} !== {1'b1, e.rd, e.rw, e.mis, e.berr}) begin
                n_bad++;
                $display("FAIL to_wb: got v=%b rd=%0d rw=%b mis=%b berr=%b, want v=1 rd=3 rw=0 mis=0 berr=1",
                         valid_o, rd_o, RegWrite_o, misalign_o, buserr_o);
            end
        end
        next_cycle();
        drive_idle();
        @(negedge clk);
        n_cmp++;
        if ({buserr_o, dmem_req_o} !== 2'b00) begin
            n_bad++;
            $display("FAIL to_pulse: got berr=%b req=%b, want 0 0", buserr_o, dmem_req_o);
        end
        // Ack on the last allowed WAIT cycle completes the access normally.
        next_cycle();
        set_op(3'b010, 32'h0000_4000, 1'b1, 1'b0, 1'b1, 5'd4, 1'b1, 32'h0);
        exp_q.push_back('{32'h1122_3344, 5'd4, 1'b1, 1'b0, 1'b0});
        @(negedge clk);
        for (int w = 1; w <= 16; w++) begin
            next_cycle();
            if (w == 16) begin
                dmem_ack_i = 1'b1;
                dmem_rdata_i = 32'h1122_3344;
            end
            @(negedge clk);
        end
        n_cmp++;
        if ({dmem_req_o, stall_o} !== 2'b10) begin
            n_bad++;
            $display("FAIL to_ack_edge: got req=%b stall=%b on 16th WAIT cycle, want req=1 stall=0", dmem_req_o, stall_o);
        end
        next_cycle();
        drive_idle();
        @(negedge clk);
        n_cmp++;
        if (exp_q.size() == 0) begin
            n_bad++;
            $display("FAIL to_ack_wb: scoreboard empty");
        end else begin
            e = exp_q.pop_front();
            if ({valid_o, wbData_o, rd_o, RegWrite_o, misalign_o, buserr_o} !== {1'b1, e.wb, e.rd, e.rw, e.mis, e.berr}) begin
                n_bad++;
                $display("FAIL to_ack_wb: got v=%b wb=%h rd=%0d rw=%b berr=%b, want v=1 wb=%h rd=4 rw=1 berr=0",
                         valid_o, wbData_o, rd_o, RegWrite_o, buserr_o, e.wb);
            end
        end
    endtask

    task automatic test_reset_in_wait();
        exp_t e;
        next_cycle();
        set_op(3'b010, 32'h0000_5000, 1'b1, 1'b0, 1'b1, 5'd6, 1'b1, 32'h0);
        @(negedge clk);
        next_cycle();
        @(negedge clk);
        next_cycle();
        reset_i = 1'b1;
        @(negedge clk);
        n_cmp++;
        if ({dmem_req_o, dmem_we_o, dmem_be_o, stall_o} !== 7'b0) begin
            n_bad++;
            $display("FAIL rw_bus: got req=%b we=%b be=%b stall=%b during reset, want 0",
                     dmem_req_o, dmem_we_o, dmem_be_o, stall_o);
        end
        next_cycle();
        reset_i = 1'b0;
        drive_idle();
        set_op(3'b000, 32'h0000_0077, 1'b0, 1'b0, 1'b0, 5'd2, 1'b0, 32'h0);
        dmem_ack_i = 1'b1;
        dmem_rdata_i = 32'hBAD0_BAD0;
        exp_q.push_back('{32'h0000_0077, 5'd2, 1'b0, 1'b0, 1'b0});
        @(negedge clk);
        n_cmp++;
        if ({wbData_o, rd_o, RegWrite_o, valid_o, misalign_o, buserr_o, dmem_req_o} !== 42'h0) begin
            n_bad++;
            $display("FAIL rw_regs: got wb=%h rd=%0d rw=%b v=%b mis=%b berr=%b req=%b, want all 0",
                     wbData_o, rd_o, RegWrite_o, valid_o, misalign_o, buserr_o, dmem_req_o);
        end
        next_cycle();
        drive_idle();
        @(negedge clk);
        n_cmp++;
        if (exp_q.size() == 0) begin
            n_bad++;
            $display("FAIL rw_wb: scoreboard empty");
        end else begin
            e = exp_q.pop_front();
            if ({valid_o, wbData_o, rd_o, RegWrite_o, buserr_o} !== {1'b1, e.wb, e.rd, e.rw, e.berr}) begin
                n_bad++;
                $display("FAIL rw_wb: got v=%b wb=%h rd=%0d rw=%b berr=%b, want v=1 wb=%h rd=2 rw=0 berr=0",
                         valid_o, wbData_o, rd_o, RegWrite_o, buserr_o, e.wb);
            end
        end
    endtask

    task automatic test_back_to_back();
        exp_t e;
        logic [4:0] req_hist;
        next_cycle();
        set_op(3'b010, 32'h0000_6000, 1'b1, 1'b0, 1'b1, 5'd8, 1'b1, 32'h0);
        exp_q.push_back('{32'hAAAA_5555, 5'd8, 1'b1, 1'b0, 1'b0});
        @(negedge clk);
        req_hist[0] = dmem_req_o;
        next_cycle();
        dmem_ack_i = 1'b1;
        dmem_rdata_i = 32'hAAAA_5555;
        @(negedge clk);
        req_hist[1] = dmem_req_o;
        next_cycle();
        dmem_ack_i = 1'b0;
        set_op(3'b100, 32'h0000_6003, 1'b1, 1'b0, 1'b1, 5'd9, 1'b1, 32'h0);
        exp_q.push_back('{32'h0000_007F, 5'd9, 1'b1, 1'b0, 1'b0});
        @(negedge clk);
        req_hist[2] = dmem_req_o;
        for (int k = 0; k < 2; k++) begin
            if (k == 1) begin
                next_cycle();
                drive_idle();
                @(negedge clk);
                req_hist[4] = dmem_req_o;
            end
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_bad++;
                $display("FAIL b2b_wb[%0d]: scoreboard empty", k);
            end else begin
                e = exp_q.pop_front();
                if ({valid_o, wbData_o, rd_o, RegWrite_o} !== {1'b1, e.wb, e.rd, e.rw}) begin
                    n_bad++;
                    $display("FAIL b2b_wb[%0d]: got v=%b wb=%h rd=%0d rw=%b, want v=1 wb=%h rd=%0d rw=%b",
                             k, valid_o, wbData_o, rd_o, RegWrite_o, e.wb, e.rd, e.rw);
                end
            end
            if (k == 0) begin
                next_cycle();
                dmem_ack_i = 1'b1;
                dmem_rdata_i = 32'h7F00_0000;
                @(negedge clk);
                req_hist[3] = dmem_req_o;
            end
        end
        n_cmp++;
        if (req_hist !== 5'b01010) begin
            n_bad++;
            $display("FAIL b2b_req: got req history %b, want 01010", req_hist);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        drive_idle();
        reset_i = 1'b1;
        test_reset();
        test_passthrough();
        test_loads();
        test_stores();
        test_misalign();
        test_timeout();
        test_reset_in_wait();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 The block SHALL have parameter TIMEOUT_CYCLES, default 16, the maximum number of WAIT cycles allowed before a bus error.
REQ-002 clk_i  in  1  sole clock; all state updates on the rising edge.
REQ-003 reset_i  in  1  synchronous, active-high reset.
REQ-004 ALUResult_i  in  32  byte address for memory ops; pass-through result for non-memory ops.
REQ-005 RDData_i  in  32  store data, from rs2.
REQ-006 rd_i  in  5  destination register; RegWrite_i  in  1  write-back enable.
REQ-007 MemRead_i  in  1  load request; MemWrite_i  in  1  store request; LoadMux_i  in  1  selects load data for write-back.
REQ-008 LoadstoreSigodecoder_i  in  3  funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU.
REQ-009 dmem_req_o  out  1  bus request; dmem_we_o  out  1  write strobe.
REQ-010 dmem_addr_o  out  32  word-aligned address, with [1:0]=00.
REQ-011 dmem_be_o  out  4  byte enables; dmem_wdata_o  out  32  lane-replicated store data.
REQ-012 dmem_ack_i  in  1  one-cycle transfer complete; dmem_rdata_i  in  32  read word, valid with ack.
REQ-013 stall_o  out  1  combinational; freezes the upstream pipeline register.
REQ-014 wbData_o  out  32; rd_o  out  5; RegWrite_o  out  1; valid_o  out  1: registered write-back outputs.
REQ-015 misalign_o  out  1; buserr_o  out  1: registered one-cycle fault pulses.

Function
REQ-016 The FSM SHALL have two states, IDLE and WAIT.
REQ-017 In IDLE with MemRead_i=MemWrite_i=0, the block SHALL register ALUResult_i, rd_i and RegWrite_i to wbData_o, rd_o and RegWrite_o with valid_o=1 one cycle later, and SHALL hold stall_o=0.
REQ-018 An access SHALL be misaligned when H/HU has addr[0]=1, or W has addr[1:0]!=00.
REQ-019 On a misaligned access in IDLE, the block SHALL make no bus request, pulse misalign_o=1 next cycle with valid_o=1 and RegWrite_o=0, and hold stall_o=0.
REQ-020 On an aligned access in IDLE, the block SHALL latch address, funct3, rd, RegWrite, LoadMux, we and store data, drive stall_o=1, and enter WAIT.
REQ-021 In WAIT, dmem_req_o SHALL be 1, and dmem_addr_o/we/be/wdata SHALL remain stable until ack.
REQ-022 In WAIT, stall_o SHALL equal ~dmem_ack_i.
REQ-023 On dmem_ack_i in WAIT, the block SHALL return to IDLE and, next cycle, present valid_o=1 with the latched rd and RegWrite.
REQ-024 wbData_o SHALL be the extracted load value when latched LoadMux=1, otherwise the latched address.
REQ-025 The minimum memory-op latency SHALL be 2 cycles from acceptance to valid_o.
REQ-026 Load extraction SHALL select byte addr[1:0] or half addr[1], then sign-extend (B/H) or zero-extend (BU/HU); W SHALL pass the word unchanged.
REQ-027 SB SHALL drive be=0001<<addr[1:0] and wdata={4{byte}}.
REQ-028 SH SHALL drive be=0011 (addr[1]=0) or 1100 (addr[1]=1) and wdata={2{half}}.
REQ-029 SW SHALL drive be=1111; dmem_be_o SHALL be 0000 whenever dmem_req_o=0.
REQ-030 Reserved funct3 values 011, 110 and 111 SHALL be treated as W.
REQ-031 A WAIT-cycle counter SHALL reset on entry to WAIT.
REQ-032 If the counter reaches TIMEOUT_CYCLES without ack, the block SHALL drop dmem_req_o, return to IDLE and pulse buserr_o=1 with valid_o=1 and RegWrite_o=0.
REQ-033 Ack arriving on the timeout cycle SHALL win over the timeout.
REQ-034 dmem_ack_i in IDLE SHALL be ignored.
REQ-035 MemRead_i=MemWrite_i=1 together SHALL be treated as a store.
REQ-036 The block SHALL never issue back-to-back requests without an intervening IDLE cycle.

Reset
REQ-037 While reset_i=1 at a clock edge, the state SHALL go to IDLE, the counter to 0, and every registered output (wbData_o, rd_o, RegWrite_o, valid_o, misalign_o, buserr_o) to 0.
REQ-038 During reset, dmem_req_o, dmem_we_o and dmem_be_o SHALL be 0.
REQ-039 Reset asserted in WAIT SHALL abandon the access with no valid_o, and SHALL ignore any later ack.
REQ-040 stall_o SHALL be 0 during reset.

Verification
REQ-041 LB at 0x1003, rdata=0x80FF_1234, ack after 3 cycles -> be=1000, stall_o high for 3 cycles, wbData_o=0xFFFF_FF80, valid_o=1.
REQ-042 SH at 0x2002 with RDData_i=0xDEAD_BEEF -> dmem_addr_o=0x2000, be=1100, wdata=0xBEEF_BEEF, we=1.
REQ-043 LW at 0x3001 -> no dmem_req_o, misalign_o=1 for one cycle, RegWrite_o=0, stall_o=0.
REQ-044 LHU at 0x4002 with ack never asserted, TIMEOUT_CYCLES=16 -> buserr_o pulse after 16 WAIT cycles, req drops, FSM returns to IDLE.
REQ-045 ADD result 0x55 with RegWrite_i=1 -> wbData_o=0x55 next cycle, no bus activity.
REQ-046 reset_i pulsed during WAIT, then ack on the following cycle -> all outputs 0, ack ignored, no valid_o.
